// File: rtl/tristate_bus_port.sv
`default_nettype none
// tristate_bus_port: registered tri-state port to an SRAM-style bus with wait states and turnaround gap.
// Define TRISTATE_READBACK_EN to compare the driven write data against the bus pins.
module tristate_bus_port #(
  parameter int N           = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int TURN_CYCLES = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req,
  input  logic         Write,
  input  logic [N-1:0] WrData,
  output logic         Ready,
  output logic [N-1:0] RdData,
  output logic         RdValid,
  output logic         WrDone,
  output logic         WrMismatch,
  output logic         BusOE,
  output logic         BusRdEn,
  inout  wire  [N-1:0] Data
);

  localparam int MAX_CNT = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
  localparam int CW      = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
  localparam bit HAS_TURN = (TURN_CYCLES > 0);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] TURN_LOAD = HAS_TURN ? CW'(TURN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  wr_reg;
  logic          accept;
  logic          phase_end;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    phase_end = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          accept    = 1'b1;
          state_nxt = Write ? WRITE : READ;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      WRITE, READ: begin
        if (cnt == '0) begin
          phase_end = 1'b1;
          if (HAS_TURN) begin
            state_nxt = TURN;
            cnt_nxt   = TURN_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      TURN: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a flop loaded from the next-state decode, so pins never glitch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_reg  <= '0;
      Ready   <= 1'b1;
      RdData  <= '0;
      RdValid <= 1'b0;
      WrDone  <= 1'b0;
      BusOE   <= 1'b0;
      BusRdEn <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      Ready   <= (state_nxt == IDLE);
      BusOE   <= (state_nxt == WRITE);
      BusRdEn <= (state_nxt == READ);
      WrDone  <= phase_end && (state == WRITE);
      RdValid <= phase_end && (state == READ);
      if (accept) begin
        wr_reg <= WrData;
      end
      if (phase_end && (state == READ)) begin
        RdData <= Data;
      end
    end
  end

`ifdef TRISTATE_READBACK_EN
  // An unknown compare result takes the else branch, so X/Z pins flag a mismatch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      WrMismatch <= 1'b0;
    end else if (phase_end && (state == WRITE)) begin
      if (Data == wr_reg) begin
        WrMismatch <= 1'b0;
      end else begin
        WrMismatch <= 1'b1;
      end
    end else begin
      WrMismatch <= 1'b0;
    end
  end
`else
  assign WrMismatch = 1'b0;
`endif

  assign Data = BusOE ? wr_reg : {N{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_port.sv
`default_nettype none
// tb_tristate_bus_port: randomized accesses checked against a cycle-offset model of the bus timing.
module tb_tristate_bus_port;

  localparam int N    = 16;
  localparam int WC   = 1;
  localparam int TC   = 1;
  localparam int LAST = WC + 2 + TC;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Req, Write;
  logic [N-1:0] WrData;
  logic         Ready, RdValid, WrDone, WrMismatch, BusOE, BusRdEn;
  logic [N-1:0] RdData;
  wire  [N-1:0] Data;
  logic [N-1:0] dev_val;

  logic         Req_b, Write_b;
  logic [N-1:0] WrData_b;
  logic         Ready_b, RdValid_b, WrDone_b, WrMismatch_b, BusOE_b, BusRdEn_b;
  logic [N-1:0] RdData_b;
  wire  [N-1:0] Data_b;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] exp_rd;

  always #5 Clk = ~Clk;

  // External device: drives its output only while the port enables it.
  assign Data   = BusRdEn   ? dev_val  : {N{1'bz}};
  assign Data_b = BusRdEn_b ? 16'h5A5A : {N{1'bz}};

  tristate_bus_port #(.N(N), .WAIT_CYCLES(WC), .TURN_CYCLES(TC)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .WrData(WrData),
    .Ready(Ready), .RdData(RdData), .RdValid(RdValid), .WrDone(WrDone),
    .WrMismatch(WrMismatch), .BusOE(BusOE), .BusRdEn(BusRdEn), .Data(Data)
  );

  tristate_bus_port #(.N(N), .WAIT_CYCLES(0), .TURN_CYCLES(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .Req(Req_b), .Write(Write_b), .WrData(WrData_b),
    .Ready(Ready_b), .RdData(RdData_b), .RdValid(RdValid_b), .WrDone(WrDone_b),
    .WrMismatch(WrMismatch_b), .BusOE(BusOE_b), .BusRdEn(BusRdEn_b), .Data(Data_b)
  );

  // One access from its accept cycle T0 to the cycle Ready returns (offset LAST).
  task automatic run_access(input bit wr, input logic [N-1:0] d, input logic [N-1:0] dv,
                            input bit hold);
    logic [5:0] got, exp;
    Req = 1'b1; Write = wr; WrData = d; dev_val = dv;
    n_cmp++;
    if (Ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready: Ready=%b expected 1", Ready);
    end
    for (int k = 1; k <= LAST; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        Req = hold; Write = 1'($urandom); WrData = 16'($urandom);
      end
      if (!wr && k == WC + 2) exp_rd = dv;
      exp = {k == LAST, wr && k <= WC + 1, !wr && k <= WC + 1,
             wr && k == WC + 2, !wr && k == WC + 2, 1'b0};
      got = {Ready, BusOE, BusRdEn, WrDone, RdValid, WrMismatch};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL access_status wr=%0d k=%0d: {rdy,oe,rden,wrdone,rdvalid,mism}=%b expected %b",
                 wr, k, got, exp);
      end
      n_cmp++;
      if (RdData !== exp_rd) begin
        n_err++; $display("FAIL rd_data k=%0d: %h expected %h", k, RdData, exp_rd);
      end
      if (wr && k <= WC + 1) begin
        n_cmp++;
        if (Data !== d) begin
          n_err++; $display("FAIL bus_data k=%0d: %h expected %h", k, Data, d);
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 1'b1; Write = 1'b1; WrData = 16'hA5A5; dev_val = '0;
    Req_b = 1'b0; Write_b = 1'b0; WrData_b = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_cmp++;
    if ({Ready, BusOE, BusRdEn, WrDone, RdValid, WrMismatch} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_status: %b expected 100000",
               {Ready, BusOE, BusRdEn, WrDone, RdValid, WrMismatch});
    end
    n_cmp++;
    if (RdData !== '0) begin
      n_err++; $display("FAIL reset_rd_data: %h expected 0000", RdData);
    end
    Reset = 1'b0; Req = 1'b0;
    exp_rd = '0;
    @(negedge Clk);
    n_cmp++;
    if ({Ready, BusOE, BusRdEn} !== 3'b100) begin
      n_err++; $display("FAIL post_reset_idle: %b expected 100", {Ready, BusOE, BusRdEn});
    end
  endtask

  task automatic test_write_read();
    run_access(1'b1, 16'hBEEF, 16'h0000, 1'b0);
    run_access(1'b0, 16'h0000, 16'h1234, 1'b0);
    dev_val = 16'hFFFF;
    repeat (3) begin
      @(negedge Clk);
      n_cmp++;
      if (RdData !== 16'h1234 || Ready !== 1'b1) begin
        n_err++; $display("FAIL rd_data_hold: RdData=%h Ready=%b expected 1234/1", RdData, Ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 16'h0F0F, 16'h0000, 1'b1);
    run_access(1'b0, 16'h0000, 16'hC3C3, 1'b1);
    run_access(1'b0, 16'h0000, 16'h3C3C, 1'b1);
    run_access(1'b1, 16'hF00D, 16'h0000, 1'b1);
    run_access(1'b1, 16'hFFFF, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 2);
      run_access(1'($urandom), 16'($urandom), 16'($urandom), gap == 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge Clk);
        n_cmp++;
        if ({Ready, BusOE, BusRdEn, WrDone, RdValid} !== 5'b10000 || RdData !== exp_rd) begin
          n_err++;
          $display("FAIL idle_gap: status=%b RdData=%h expected 10000/%h",
                   {Ready, BusOE, BusRdEn, WrDone, RdValid}, RdData, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    Req = 1'b1; Write = 1'b1; WrData = 16'h7777;
    @(negedge Clk);
    Req = 1'b0;
    n_cmp++;
    if (BusOE !== 1'b1) begin
      n_err++; $display("FAIL abort_t1_oe: BusOE=%b expected 1", BusOE);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    exp_rd = '0;
    n_cmp++;
    if ({Ready, BusOE, BusRdEn} !== 3'b100) begin
      n_err++; $display("FAIL abort_t2: {rdy,oe,rden}=%b expected 100", {Ready, BusOE, BusRdEn});
    end
    repeat (WC + TC + 3) begin
      @(negedge Clk);
      n_cmp++;
      if ({WrDone, BusOE, Ready} !== 3'b001) begin
        n_err++; $display("FAIL abort_quiet: {wrdone,oe,rdy}=%b expected 001", {WrDone, BusOE, Ready});
      end
    end
  endtask

  // Zero wait, zero turn: period 2, accepts at T0, T2, T4.
  task automatic test_zero_wait();
    logic [N-1:0] d1, d2;
    logic [4:0]   got;
    logic [4:0]   exp_tab [0:6];
    d1 = 16'($urandom); d2 = 16'($urandom);
    exp_tab[0] = 5'b10000; exp_tab[1] = 5'b01000; exp_tab[2] = 5'b10010;
    exp_tab[3] = 5'b00100; exp_tab[4] = 5'b10001; exp_tab[5] = 5'b01000;
    exp_tab[6] = 5'b10010;
    Req_b = 1'b1; Write_b = 1'b1; WrData_b = d1;
    for (int t = 0; t <= 6; t++) begin
      if (t > 0) @(negedge Clk);
      if (t == 1) Write_b = 1'b0;
      if (t == 3) begin Write_b = 1'b1; WrData_b = d2; end
      if (t == 5) Req_b = 1'b0;
      got = {Ready_b, BusOE_b, BusRdEn_b, WrDone_b, RdValid_b};
      n_cmp++;
      if (got !== exp_tab[t] || WrMismatch_b !== 1'b0) begin
        n_err++;
        $display("FAIL zero_wait_status T%0d: {rdy,oe,rden,wrdone,rdvalid}=%b mism=%b expected %b/0",
                 t, got, WrMismatch_b, exp_tab[t]);
      end
      if (t == 1 || t == 5) begin
        n_cmp++;
        if (Data_b !== (t == 1 ? d1 : d2)) begin
          n_err++; $display("FAIL zero_wait_data T%0d: %h expected %h", t, Data_b, (t == 1 ? d1 : d2));
        end
      end
      if (t == 4) begin
        n_cmp++;
        if (RdData_b !== 16'h5A5A) begin
          n_err++; $display("FAIL zero_wait_rd T4: %h expected 5a5a", RdData_b);
        end
      end
    end
  endtask

`ifdef TRISTATE_READBACK_EN
  task automatic test_readback();
    Req = 1'b1; Write = 1'b1; WrData = 16'h0001;
    @(negedge Clk);
    Req = 1'b0;
    force Data = 16'h0000;
    @(negedge Clk);
    @(negedge Clk);
    release Data;
    n_cmp++;
    if ({WrDone, WrMismatch} !== 2'b11) begin
      n_err++; $display("FAIL readback_stuck: {wrdone,mism}=%b expected 11", {WrDone, WrMismatch});
    end
    @(negedge Clk);
    run_access(1'b1, 16'hBEEF, 16'h0000, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_zero_wait();
`ifdef TRISTATE_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
